// File: rtl/hdmi_pattern_gen.sv
// hdmi_pattern_gen: frame-synchronous video test-pattern source driven by hdmi scan coordinates.
// Modes: solid, colour bars, checkerboard, gradient, LFSR noise, row-code stripes.
module hdmi_pattern_gen #(
   parameter int                      COLOR_BITS    = 8,
   parameter int                      X_WIDTH       = 10,
   parameter int                      Y_WIDTH       = 10,
   parameter int                      ACTIVE_W      = 640,
   parameter int                      ACTIVE_H      = 480,
   parameter int                      CELL_SHIFT    = 4,
   parameter logic [3*COLOR_BITS-1:0] LFSR_SEED     = 24'hACE001,
   parameter logic [7:0]              ROW_CODE_BASE = 8'h30
) (
   input  logic                      clk_pixel,
   input  logic                      rst_n,
   input  logic [X_WIDTH-1:0]        cx,
   input  logic [Y_WIDTH-1:0]        cy,
   input  logic [2:0]                mode,
   input  logic                      noise_freeze,
   output logic [3*COLOR_BITS-1:0]   rgb,
   output logic [7:0]                row_code,
   output logic                      frame_start,
   output logic [15:0]               frame_count
);
   localparam int RW    = 3*COLOR_BITS;
   localparam int BAR_W = ACTIVE_W/8;
   localparam int BW    = Y_WIDTH - CELL_SHIFT;

   logic [2:0]    r_mode;
   logic [RW-1:0] r_lfsr;
   logic [BW-1:0] r_band;
   logic          w_fs, w_active, w_reseed, w_fb;
   logic [2:0]    w_mode, w_bar;
   logic [RW-1:0] w_lfsr, w_rgb;
   logic [7:0]    w_code;
   logic [BW-1:0] w_band;

   // Palette index bits map directly to absent channels: white,yellow,cyan,green,magenta,red,blue,black.
   function automatic logic [RW-1:0] pal(input logic [2:0] idx);
      return {{COLOR_BITS{~idx[1]}}, {COLOR_BITS{~idx[2]}}, {COLOR_BITS{~idx[0]}}};
   endfunction

   always_comb begin
      w_bar = '0;
      for (int i = 1; i < 8; i++)
         if (32'(cx) >= i*BAR_W) w_bar = 3'(i);
   end

   always_comb begin
      w_fs     = (cx == '0) && (cy == '0);
      w_active = (32'(cx) < ACTIVE_W) && (32'(cy) < ACTIVE_H);
      w_mode   = w_fs ? mode : r_mode;
      w_reseed = w_fs && noise_freeze;
      w_lfsr   = w_reseed ? LFSR_SEED : r_lfsr;
      w_fb     = r_lfsr[RW-1] ^ r_lfsr[RW-2] ^ r_lfsr[RW-3] ^ r_lfsr[RW-8];
      w_band   = cy[Y_WIDTH-1:CELL_SHIFT];
      w_code   = (cy == '0) ? ROW_CODE_BASE : (w_band != r_band) ? row_code + 8'd1 : row_code;
      case (w_mode)
         3'd1:    w_rgb = pal(w_bar);
         3'd2:    w_rgb = {RW{cx[CELL_SHIFT] ^ cy[CELL_SHIFT]}};
         3'd3:    w_rgb = {3{cx[COLOR_BITS-1:0]}};
         3'd4:    w_rgb = w_lfsr;
         3'd5:    w_rgb = pal(w_code[2:0]);
         default: w_rgb = '0;
      endcase
      if (!w_active) w_rgb = '0;
   end

   always_ff @(posedge clk_pixel or negedge rst_n)
      if (!rst_n) begin
         r_mode      <= '0;
         r_lfsr      <= LFSR_SEED;
         r_band      <= '0;
         rgb         <= '0;
         row_code    <= ROW_CODE_BASE;
         frame_start <= 1'b0;
         frame_count <= '0;
      end else begin
         r_mode      <= w_mode;
         r_lfsr      <= w_reseed ? LFSR_SEED : w_active ? {r_lfsr[RW-2:0], w_fb} : r_lfsr;
         r_band      <= w_band;
         rgb         <= w_rgb;
         row_code    <= w_code;
         frame_start <= w_fs;
         frame_count <= frame_count + {15'd0, w_fs};
      end
endmodule

// File: tb/tb_hdmi_pattern_gen.sv
// tb_hdmi_pattern_gen: raster/random stimulus against a behavioural pattern model, plus literal pins.
module tb_hdmi_pattern_gen;
   localparam int CB = 8, XW = 10, YW = 10, AW = 32, AH = 16, CS = 2, HT = 40, VT = 20;
   localparam logic [23:0] SEED = 24'hACE001;
   localparam logic [7:0]  BASE = 8'h30;

   logic          clk_pixel = 1'b0, rst_n = 1'b1;
   logic [XW-1:0] cx = '0;
   logic [YW-1:0] cy = '0;
   logic [2:0]    mode = '0;
   logic          noise_freeze = 1'b0;
   logic [23:0]   rgb;
   logic [7:0]    row_code;
   logic          frame_start;
   logic [15:0]   frame_count;

   int          n_cmp = 0, n_bad = 0, fs_seen = 0, chg_x = -1, chg_y = -1;
   bit          rnd = 1'b0;
   logic [2:0]  chg_mode = '0;
   logic [23:0] cap [VT][HT];
   logic [23:0] prev [VT][HT];
   logic [7:0]  rc [VT];

   logic [2:0]  m_mode;
   logic [23:0] m_lfsr, e_rgb;
   logic [7:0]  m_code, e_code;
   int          m_band;
   logic [15:0] m_fc, e_fc;
   logic        e_fs;

   hdmi_pattern_gen #(.COLOR_BITS(CB), .X_WIDTH(XW), .Y_WIDTH(YW), .ACTIVE_W(AW), .ACTIVE_H(AH),
                      .CELL_SHIFT(CS), .LFSR_SEED(SEED), .ROW_CODE_BASE(BASE)) dut (
      .clk_pixel(clk_pixel), .rst_n(rst_n), .cx(cx), .cy(cy), .mode(mode),
      .noise_freeze(noise_freeze), .rgb(rgb), .row_code(row_code),
      .frame_start(frame_start), .frame_count(frame_count));

   always #5 clk_pixel = ~clk_pixel;

   function automatic logic [23:0] bar_color(input int i);
      case (i)
         0: return 24'hFFFFFF;
         1: return 24'hFFFF00;
         2: return 24'h00FFFF;
         3: return 24'h00FF00;
         4: return 24'hFF00FF;
         5: return 24'hFF0000;
         6: return 24'h0000FF;
         default: return 24'h000000;
      endcase
   endfunction

   function automatic logic [23:0] lstep(input logic [23:0] l);
      return {l[22:0], l[23] ^ l[22] ^ l[21] ^ l[16]};
   endfunction

   always @(posedge clk_pixel or negedge rst_n) begin : model
      bit          fs, act;
      logic [2:0]  md;
      logic [23:0] lf;
      if (!rst_n) begin
         m_mode = 0; m_lfsr = SEED; m_code = BASE; m_band = 0; m_fc = 0;
         e_rgb = 0; e_code = BASE; e_fs = 0; e_fc = 0;
      end else begin
         fs  = (cx == 0) && (cy == 0);
         act = (int'(cx) < AW) && (int'(cy) < AH);
         md  = fs ? mode : m_mode;
         lf  = (fs && noise_freeze) ? SEED : m_lfsr;
         m_code = (cy == 0) ? BASE : ((int'(cy) >> CS) != m_band) ? m_code + 8'd1 : m_code;
         m_band = int'(cy) >> CS;
         case (md)
            3'd1: e_rgb = bar_color(int'(cx) / (AW/8));
            3'd2: e_rgb = (((int'(cx) >> CS) ^ (int'(cy) >> CS)) & 1) != 0 ? 24'hFFFFFF : 24'h0;
            3'd3: e_rgb = {3{cx[7:0]}};
            3'd4: e_rgb = lf;
            3'd5: e_rgb = bar_color(int'(m_code) % 8);
            default: e_rgb = 24'h0;
         endcase
         if (!act) e_rgb = 24'h0;
         m_lfsr = (fs && noise_freeze) ? SEED : act ? lstep(m_lfsr) : m_lfsr;
         m_mode = md;
         m_fc   = m_fc + 16'(fs);
         e_code = m_code;
         e_fs   = fs;
         e_fc   = m_fc;
      end
   end

   always @(negedge clk_pixel) begin
      n_cmp++;
      if (rgb !== e_rgb || row_code !== e_code || frame_start !== e_fs || frame_count !== e_fc) begin
         n_bad++;
         if (n_bad <= 20)
            $display("FAIL cycle t=%0t cx=%0d cy=%0d: rgb %h want %h, row_code %h want %h, fs %b want %b, fc %h want %h",
                     $time, cx, cy, rgb, e_rgb, row_code, e_code, frame_start, e_fs, frame_count, e_fc);
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, got, exp);
      end
   endtask

   task automatic tick(input int x, input int y);
      cx = XW'(x);
      cy = YW'(y);
      if (x == chg_x && y == chg_y) mode = chg_mode;
      if (rnd) begin
         mode = 3'($urandom_range(0, 7));
         noise_freeze = 1'($urandom_range(0, 1));
      end
      @(posedge clk_pixel);
      #1;
      if (x < HT && y < VT) cap[y][x] = rgb;
      if (x == 0 && y < VT) rc[y] = row_code;
      fs_seen += int'(frame_start);
   endtask

   task automatic rows(input int y0, input int y1);
      for (int y = y0; y <= y1; y++)
         for (int x = 0; x < HT; x++) tick(x, y);
   endtask

   task automatic frame();
      fs_seen = 0;
      rows(0, VT-1);
   endtask

   initial begin
      int ndiff;
      #2 rst_n = 1'b0;
      #1;
      chk("reset_rgb", 32'(rgb), 32'h0);
      chk("reset_row_code", 32'(row_code), 32'(BASE));
      chk("reset_frame_start", 32'(frame_start), 32'h0);
      chk("reset_frame_count", 32'(frame_count), 32'h0);
      @(posedge clk_pixel);
      #1 rst_n = 1'b1;

      mode = 3'd1;
      frame();
      chk("bar_white", 32'(cap[0][0]), 32'hFFFFFF);
      chk("bar_yellow", 32'(cap[0][4]), 32'hFFFF00);
      chk("bar_cyan", 32'(cap[2][8]), 32'h00FFFF);
      chk("bar_red", 32'(cap[3][20]), 32'hFF0000);
      chk("bar_blue", 32'(cap[15][27]), 32'h0000FF);
      chk("bar_black", 32'(cap[15][28]), 32'h0);
      chk("bar_blank_x", 32'(cap[0][32]), 32'h0);
      chk("bar_blank_y", 32'(cap[16][0]), 32'h0);
      chk("fs_once_bars", 32'(fs_seen), 32'd1);
      chk("row_band0_first", 32'(rc[0]), 32'h30);
      chk("row_band0_last", 32'(rc[3]), 32'h30);
      chk("row_band1", 32'(rc[4]), 32'h31);
      chk("row_last_active", 32'(rc[15]), 32'h33);
      chk("row_vblank", 32'(rc[19]), 32'h34);
      tick(700, 5);
      chk("far_x_black", 32'(rgb), 32'h0);

      mode = 3'd4;
      noise_freeze = 1'b1;
      frame();
      prev = cap;
      frame();
      chk("row_base_again", 32'(rc[0]), 32'h30);
      chk("noise_seed_px0", 32'(cap[0][0]), 32'hACE001);
      chk("noise_seed_px1", 32'(cap[0][1]), 32'hACE001);
      chk("noise_step_px2", 32'(cap[0][2]), 32'h59C002);
      ndiff = 0;
      for (int y = 0; y < VT; y++)
         for (int x = 0; x < HT; x++) ndiff += int'(cap[y][x] != prev[y][x]);
      chk("freeze_repeat", 32'(ndiff), 32'd0);

      noise_freeze = 1'b0;
      frame();
      prev = cap;
      frame();
      chk("nofreeze_differ", 32'(cap[0][0] != prev[0][0]), 32'd1);

      mode = 3'd1;
      chg_x = 10; chg_y = 5; chg_mode = 3'd2;
      frame();
      chk("bars_after_change", 32'(cap[10][20]), 32'hFF0000);
      chk("fs_once_change", 32'(fs_seen), 32'd1);
      chg_x = -1; chg_y = -1;
      frame();
      chk("checker_00", 32'(cap[0][0]), 32'h0);
      chk("checker_x4", 32'(cap[0][4]), 32'hFFFFFF);
      chk("checker_y4", 32'(cap[4][0]), 32'hFFFFFF);
      chk("checker_xy4", 32'(cap[4][4]), 32'h0);

      mode = 3'd5;
      frame();
      chk("stripe_band0", 32'(cap[0][0]), 32'hFFFFFF);
      chk("stripe_band1", 32'(cap[4][9]), 32'hFFFF00);

      mode = 3'd3;
      frame();
      chk("gradient", 32'(cap[1][17]), 32'h111111);
      rows(0, 7);
      rst_n = 1'b0;
      #1;
      chk("async_rst_rgb", 32'(rgb), 32'h0);
      chk("async_rst_fc", 32'(frame_count), 32'h0);
      @(posedge clk_pixel);
      #1 rst_n = 1'b1;
      rows(8, VT-1);
      chk("post_reset_black", 32'(cap[10][17]), 32'h0);
      frame();
      chk("gradient_resumes", 32'(cap[1][17]), 32'h111111);

      rnd = 1'b1;
      repeat (6) frame();
      rnd = 1'b0;

      mode = 3'd0;
      for (int i = 0; i < 70000 && m_fc != 16'hFFFF; i++) tick(0, 0);
      chk("fc_max", 32'(frame_count), 32'hFFFF);
      tick(0, 0);
      chk("fc_wrap", 32'(frame_count), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
